// File: rtl/input_feeder_pkg.sv
// Shared types and sizing for the input feeder: state encoding and buffer geometry.
// Geometry comes from `BIN_LEN, `INPUT_WIDTH and `INPUT_HEIGHT (defaults 8, 4, 4).
`ifndef BIN_LEN
`define BIN_LEN 8
`endif
`ifndef INPUT_WIDTH
`define INPUT_WIDTH 4
`endif
`ifndef INPUT_HEIGHT
`define INPUT_HEIGHT 4
`endif

package input_feeder_pkg;

  localparam int unsigned FEEDER_BIN_LEN = `BIN_LEN;
  localparam int unsigned FEEDER_DEPTH   = `INPUT_WIDTH * `INPUT_HEIGHT;
  localparam int unsigned FEEDER_ADDR_W  = (FEEDER_DEPTH > 1) ? $clog2(FEEDER_DEPTH) : 1;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StLoaded,
    StServe,
    StRd,
    StResp,
    StGap,
    StDone
  } feeder_state_e;

endpackage

// File: rtl/feeder_buffer.sv
// Feature-map store for the input feeder: 1R1W synchronous RAM with a registered read port.
module feeder_buffer #(
  parameter int unsigned Width = 8,
  parameter int unsigned Depth = 16,
  parameter int unsigned AddrW = 4
) (
  input  logic             clock,
  input  logic             wr_en,
  input  logic [AddrW-1:0] wr_addr,
  input  logic [Width-1:0] wr_data,
  input  logic             rd_en,
  input  logic [AddrW-1:0] rd_addr,
  output logic [Width-1:0] rd_data
);

  logic [Width-1:0] mem_q [Depth];

  always_ff @(posedge clock) begin
    if (wr_en) mem_q[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem_q[rd_addr];
  end

endmodule

// File: rtl/input_feeder.sv
// Input feeder: host loads one feature map, processing_unit then pulls it value by value.
// Define INPUT_FEEDER_PREFETCH_EN to preload the next value and cut response latency to 1.
module input_feeder
  import input_feeder_pkg::*;
(
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      load_start,
  input  logic                      wr_en,
  input  logic [FEEDER_BIN_LEN-1:0] wr_data,
  output logic                      wr_reject,
  output logic                      load_done,
  input  logic                      serve_start,
  input  logic                      input_req,
  output logic [FEEDER_BIN_LEN-1:0] input_val,
  output logic                      input_ready,
  output logic                      feeder_done
);

  localparam int unsigned DEPTH  = FEEDER_DEPTH;
  localparam int unsigned ADDR_W = FEEDER_ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  feeder_state_e             state_q;
  logic [ADDR_W-1:0]         wr_ptr_q, rd_ptr_q, rd_addr;
  logic                      last_q;
  logic [FEEDER_BIN_LEN-1:0] rd_data;
  logic                      accept, serve_go, mem_wr, mem_rd, rd_wrap;

  assign accept   = (state_q == StServe) && input_req;
  assign serve_go = serve_start && ((state_q == StLoaded) || (state_q == StDone));
  assign mem_wr   = (state_q == StLoad) && wr_en && !load_start;
  assign rd_wrap  = (rd_ptr_q == LAST_ADDR);

  // Read address tracks the pointer value of the next cycle so prefetched data is never stale.
  always_comb begin
    rd_addr = rd_ptr_q;
    if (serve_go) begin
      rd_addr = '0;
    end else if (state_q == StResp) begin
      rd_addr = rd_wrap ? '0 : rd_ptr_q + 1'b1;
    end
  end

`ifdef INPUT_FEEDER_PREFETCH_EN
  assign mem_rd = 1'b1;
`else
  assign mem_rd = accept;
`endif

  feeder_buffer #(
    .Width(FEEDER_BIN_LEN),
    .Depth(DEPTH),
    .AddrW(ADDR_W)
  ) u_buffer (
    .clock  (clock),
    .wr_en  (mem_wr),
    .wr_addr(wr_ptr_q),
    .wr_data(wr_data),
    .rd_en  (mem_rd),
    .rd_addr(rd_addr),
    .rd_data(rd_data)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= StIdle;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      last_q      <= 1'b0;
      wr_reject   <= 1'b0;
      load_done   <= 1'b0;
      input_val   <= '0;
      input_ready <= 1'b0;
      feeder_done <= 1'b0;
    end else begin
      wr_reject   <= wr_en && ((state_q != StLoad) || load_start);
      input_ready <= 1'b0;
      // load_start overrides everything, including an in-flight response.
      if (load_start) begin
        state_q     <= StLoad;
        wr_ptr_q    <= '0;
        load_done   <= 1'b0;
        feeder_done <= 1'b0;
      end else begin
        unique case (state_q)
          StLoad: begin
            if (wr_en) begin
              wr_ptr_q <= wr_ptr_q + 1'b1;
              if (wr_ptr_q == LAST_ADDR) begin
                state_q   <= StLoaded;
                load_done <= 1'b1;
              end
            end
          end
          StLoaded, StDone: begin
            if (serve_start) begin
              state_q     <= StServe;
              rd_ptr_q    <= '0;
              feeder_done <= 1'b0;
            end
          end
          StServe: begin
            if (accept) begin
`ifdef INPUT_FEEDER_PREFETCH_EN
              input_val   <= rd_data;
              input_ready <= 1'b1;
              state_q     <= StResp;
`else
              state_q     <= StRd;
`endif
            end
          end
          StRd: begin
            input_val   <= rd_data;
            input_ready <= 1'b1;
            state_q     <= StResp;
          end
          StResp: begin
            rd_ptr_q <= rd_addr;
            last_q   <= rd_wrap;
            state_q  <= StGap;
          end
          StGap: begin
            if (last_q) begin
              state_q     <= StDone;
              feeder_done <= 1'b1;
            end else begin
              state_q <= StServe;
            end
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_input_feeder.sv
// Self-checking bench for input_feeder: table of load/serve scenarios plus corner sequences.
module tb_input_feeder;
  import input_feeder_pkg::*;

  localparam int unsigned W     = FEEDER_BIN_LEN;
  localparam int unsigned DEPTH = FEEDER_DEPTH;
`ifdef INPUT_FEEDER_PREFETCH_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 2;
`endif

  logic         clock = 1'b0;
  logic         reset, load_start, wr_en, serve_start, input_req;
  logic [W-1:0] wr_data, input_val;
  logic         wr_reject, load_done, input_ready, feeder_done;

  int           checks = 0;
  int           errors = 0;
  int           ready_cnt = 0;
  logic [W-1:0] exp_q[$];

  typedef struct {
    int base;
    int passes;
  } scen_t;

  always #5 clock = ~clock;

  always @(negedge clock) if (input_ready === 1'b1) ready_cnt++;

  input_feeder dut (
    .clock      (clock),
    .reset      (reset),
    .load_start (load_start),
    .wr_en      (wr_en),
    .wr_data    (wr_data),
    .wr_reject  (wr_reject),
    .load_done  (load_done),
    .serve_start(serve_start),
    .input_req  (input_req),
    .input_val  (input_val),
    .input_ready(input_ready),
    .feeder_done(feeder_done)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1; load_start = 1'b0; wr_en = 1'b0; serve_start = 1'b0; input_req = 1'b0;
    wr_data = '0;
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic pulse_load();
    load_start = 1'b1;
    @(negedge clock);
    load_start = 1'b0;
  endtask

  task automatic write_word(input logic [W-1:0] v, input logic exp_rej);
    wr_en = 1'b1; wr_data = v;
    @(negedge clock);
    wr_en = 1'b0;
    check("wr_reject", wr_reject, exp_rej);
  endtask

  task automatic load_map(input int base);
    pulse_load();
    check("load_done_cleared", load_done, 0);
    for (int i = 0; i < DEPTH; i++) write_word(W'(base + i), 1'b0);
    check("load_done_set", load_done, 1);
  endtask

  task automatic pulse_serve();
    serve_start = 1'b1;
    @(negedge clock);
    serve_start = 1'b0;
  endtask

  // Called in a SERVE cycle; raises req, holds it until the response, then lets GAP pass.
  task automatic request(input logic [W-1:0] v);
    int cnt;
    logic [W-1:0] e;
    exp_q.push_back(v);
    input_req = 1'b1;
    cnt = 0;
    do begin
      @(negedge clock);
      cnt++;
    end while (input_ready !== 1'b1 && cnt < 10);
    e = exp_q.pop_front();
    check("response_seen", input_ready, 1);
    check("latency", cnt, LAT);
    check("input_val", input_val, e);
    input_req = 1'b0;
    @(negedge clock);
    @(negedge clock);
  endtask

  task automatic serve_pass(input int base);
    pulse_serve();
    check("done_clear_on_serve", feeder_done, 0);
    for (int i = 0; i < DEPTH; i++) begin
      request(W'(base + i));
      check("feeder_done", feeder_done, (i == DEPTH - 1) ? 1 : 0);
    end
  endtask

  scen_t scen[3];
  int    r0;

  initial begin
    scen[0] = '{base: 1,   passes: 1};
    scen[1] = '{base: 100, passes: 2};
    scen[2] = '{base: 224, passes: 1};

    do_reset();
    check("rst_wr_reject", wr_reject, 0);
    check("rst_load_done", load_done, 0);
    check("rst_input_ready", input_ready, 0);
    check("rst_input_val", input_val, 0);
    check("rst_feeder_done", feeder_done, 0);
    write_word(8'h33, 1'b1);

    for (int s = 0; s < 3; s++) begin
      load_map(scen[s].base);
      for (int p = 0; p < scen[s].passes; p++) serve_pass(scen[s].base);
    end

    // Requests while DONE are ignored; a fresh serve replays the map.
    r0 = ready_cnt;
    input_req = 1'b1;
    repeat (5) @(negedge clock);
    input_req = 1'b0;
    check("req_in_done_ignored", ready_cnt, r0);
    check("done_holds", feeder_done, 1);
    serve_pass(224);

    // Write dropped when it coincides with load_start; writes after LOADED rejected.
    load_start = 1'b1; wr_en = 1'b1; wr_data = 8'h55;
    @(negedge clock);
    load_start = 1'b0; wr_en = 1'b0;
    check("reject_with_load_start", wr_reject, 1);
    for (int i = 0; i < DEPTH; i++) write_word(W'(1 + i), 1'b0);
    check("loaded", load_done, 1);
    write_word(8'hAA, 1'b1);
    write_word(8'hBB, 1'b1);
    check("still_loaded", load_done, 1);
    serve_pass(1);

    // Request raised mid-load stalls until serving begins.
    do_reset();
    pulse_load();
    for (int i = 0; i < 10; i++) write_word(W'(1 + i), 1'b0);
    r0 = ready_cnt;
    input_req = 1'b1;
    for (int i = 10; i < DEPTH; i++) write_word(W'(1 + i), 1'b0);
    @(negedge clock);
    check("no_ready_before_serve", ready_cnt, r0);
    pulse_serve();
    for (int i = 0; i < DEPTH; i++) request(W'(1 + i));
    check("done_after_early_req", feeder_done, 1);

    // load_start aborts an outstanding request.
    pulse_serve();
    r0 = ready_cnt;
    input_req = 1'b1;
`ifndef INPUT_FEEDER_PREFETCH_EN
    @(negedge clock);
`endif
    load_start = 1'b1;
    @(negedge clock);
    load_start = 1'b0; input_req = 1'b0;
    repeat (3) @(negedge clock);
    check("abort_no_ready", ready_cnt, r0);
    check("abort_load_done", load_done, 0);
    for (int i = 0; i < DEPTH; i++) write_word(W'(100 + i), 1'b0);
    serve_pass(100);

    // Reset during RESP returns everything to idle.
    pulse_serve();
    input_req = 1'b1;
    repeat (LAT) @(negedge clock);
    check("in_resp", input_ready, 1);
    reset = 1'b1; input_req = 1'b0;
    @(negedge clock);
    check("rst_mid_ready", input_ready, 0);
    check("rst_mid_done", feeder_done, 0);
    check("rst_mid_load_done", load_done, 0);
    check("rst_mid_val", input_val, 0);
    reset = 1'b0;
    write_word(8'h11, 1'b1);
    r0 = ready_cnt;
    serve_start = 1'b1; input_req = 1'b1;
    @(negedge clock);
    serve_start = 1'b0;
    repeat (4) @(negedge clock);
    input_req = 1'b0;
    check("idle_ignores_serve", ready_cnt, r0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
